// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-boundary config apply, receiver enable gating, clean-byte FIFO and error counters.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cfg_wr,
    input  logic                          i_cfg_par_en,
    input  logic                          i_cfg_par_typ,
    input  logic [5:0]                    i_cfg_prescale,
    output logic                          o_cfg_busy,
    output logic                          o_cfg_ack,
    output logic                          o_par_en,
    output logic                          o_par_typ,
    output logic [5:0]                    o_prescale,
    output logic                          o_rx_en,
    input  logic                          i_rx_busy,
    input  logic [DATA_WIDTH-1:0]         i_rx_data,
    input  logic                          i_rx_data_valid,
    input  logic                          i_rx_par_err,
    input  logic                          i_rx_stp_err,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overrun,
    output logic [CNT_WIDTH-1:0]          o_par_err_cnt,
    output logic [CNT_WIDTH-1:0]          o_stp_err_cnt,
    input  logic                          i_clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_APPLY = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_pend_par_en;
    logic                  r_pend_par_typ;
    logic [5:0]            r_pend_prescale;
    logic                  w_accept;
    logic                  w_apply;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_level;
    logic                  w_clean;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_par_inc;
    logic                  w_stp_inc;

    always_comb begin
        w_state_nxt = r_state == S_INIT  ? S_RUN :
                      r_state == S_RUN   ? (i_cfg_wr ? S_DRAIN : S_RUN) :
                      r_state == S_DRAIN ? (i_rx_busy ? S_DRAIN : S_APPLY) :
                                           S_RUN;
        w_accept  = r_state == S_RUN && i_cfg_wr;
        w_apply   = r_state == S_DRAIN && !i_rx_busy;
        w_clean   = i_rx_data_valid && !i_rx_par_err && !i_rx_stp_err;
        w_full    = r_level == (AW+1)'(FIFO_DEPTH);
        w_pop     = o_rd_valid && i_rd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        w_push    = w_clean && (!w_full || w_pop);
        w_drop    = w_clean && w_full && !w_pop;
        w_par_inc = i_rx_data_valid && i_rx_par_err;
        w_stp_inc = i_rx_data_valid && i_rx_stp_err;
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_rd_valid = r_level != '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= S_INIT;
            o_rx_en         <= 1'b0;
            o_cfg_busy      <= 1'b0;
            o_cfg_ack       <= 1'b0;
            o_par_en        <= 1'b1;
            o_par_typ       <= 1'b0;
            o_prescale      <= 6'd8;
            r_pend_par_en   <= 1'b1;
            r_pend_par_typ  <= 1'b0;
            r_pend_prescale <= 6'd8;
        end else begin
            r_state    <= w_state_nxt;
            o_rx_en    <= w_state_nxt == S_RUN;
            o_cfg_busy <= w_state_nxt == S_DRAIN || w_state_nxt == S_APPLY;
            o_cfg_ack  <= w_apply;
            if (w_accept) begin
                r_pend_par_en   <= i_cfg_par_en;
                r_pend_par_typ  <= i_cfg_par_typ;
                r_pend_prescale <= i_cfg_prescale;
            end
            if (w_apply) begin
                o_par_en   <= r_pend_par_en;
                o_par_typ  <= r_pend_par_typ;
                o_prescale <= r_pend_prescale;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            o_fifo_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_rx_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level      <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            o_fifo_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr_err) begin
            o_overrun     <= 1'b0;
            o_par_err_cnt <= '0;
            o_stp_err_cnt <= '0;
        end else begin
            if (w_drop) o_overrun <= 1'b1;
            if (w_par_inc && o_par_err_cnt != '1) o_par_err_cnt <= o_par_err_cnt + CNT_WIDTH'(1);
            if (w_stp_inc && o_stp_err_cnt != '1) o_stp_err_cnt <= o_stp_err_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table-driven vectors plus directed sequences for drain, saturation and reset.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, cfg_wr, cfg_par_en, cfg_par_typ;
    logic [5:0] cfg_prescale;
    logic       cfg_busy, cfg_ack, par_en, par_typ, rx_en;
    logic [5:0] prescale;
    logic       rx_busy, rx_dv, rx_perr, rx_serr, rd_ready, clr_err;
    logic [7:0] rx_data, rd_data, par_cnt, stp_cnt;
    logic       rd_valid, overrun;
    logic [2:0] level;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int rst_n, cw, pen, ptyp, ps, busy, dv, data, perr, serr, rdy, clr;
        int e_rxen, e_busy, e_ack, e_pen, e_ptyp, e_ps, e_rv, e_rd, e_lvl, e_ovr;
    } vec_t;
    vec_t tbl[$];

    uart_rx_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_par_en(cfg_par_en),
        .i_cfg_par_typ(cfg_par_typ), .i_cfg_prescale(cfg_prescale), .o_cfg_busy(cfg_busy),
        .o_cfg_ack(cfg_ack), .o_par_en(par_en), .o_par_typ(par_typ), .o_prescale(prescale),
        .o_rx_en(rx_en), .i_rx_busy(rx_busy), .i_rx_data(rx_data), .i_rx_data_valid(rx_dv),
        .i_rx_par_err(rx_perr), .i_rx_stp_err(rx_serr), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_fifo_level(level),
        .o_overrun(overrun), .o_par_err_cnt(par_cnt), .o_stp_err_cnt(stp_cnt),
        .i_clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1; cfg_wr = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = 0;
        rx_busy = 0; rx_dv = 0; rx_data = 0; rx_perr = 0; rx_serr = 0;
        rd_ready = 0; clr_err = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int rst_n_, cw, pen, ptyp, ps, busy, dv, data, perr, serr, rdy, clr,
                       erx, ebusy, eack, epen, eptyp, eps, erv, erd, elvl, eovr);
        vec_t v;
        v = '{rst_n_, cw, pen, ptyp, ps, busy, dv, data, perr, serr, rdy, clr,
              erx, ebusy, eack, epen, eptyp, eps, erv, erd, elvl, eovr};
        tbl.push_back(v);
    endtask

    task automatic chk_cfg(input string nm, input int erx, ebusy, eack, epen, eptyp, eps);
        chk({nm, " rx_en"}, int'(rx_en), erx);
        chk({nm, " cfg_busy"}, int'(cfg_busy), ebusy);
        chk({nm, " cfg_ack"}, int'(cfg_ack), eack);
        chk({nm, " par_en"}, int'(par_en), epen);
        chk({nm, " par_typ"}, int'(par_typ), eptyp);
        chk({nm, " prescale"}, int'(prescale), eps);
    endtask

    initial begin
        idle();
        //   rst cw pen typ ps busy dv data perr serr rdy clr | rxen bsy ack pen typ ps rv rd lvl ovr
        add(0, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 0, 0,   0, 0, 0, 1, 0, 8,  0, 'h00, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 0, 0,   1, 0, 0, 1, 0, 8,  0, 'h00, 0, 0);
        add(1, 1, 0, 1, 16, 0, 0, 'h00, 0, 0, 0, 0,   0, 1, 0, 1, 0, 8,  0, 'h00, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 0, 0,   0, 1, 1, 0, 1, 16, 0, 'h00, 0, 0);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 0, 'h00, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 'h11, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 1, 'h11, 1, 0);
        add(1, 0, 0, 0, 0,  0, 1, 'h22, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 1, 'h11, 2, 0);
        add(1, 0, 0, 0, 0,  0, 1, 'h33, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 1, 'h11, 3, 0);
        add(1, 0, 0, 0, 0,  0, 1, 'h44, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 1, 'h11, 4, 0);
        add(1, 0, 0, 0, 0,  0, 1, 'h55, 0, 0, 0, 0,   1, 0, 0, 0, 1, 16, 1, 'h11, 4, 1);
        add(1, 0, 0, 0, 0,  0, 1, 'h66, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 1, 'h22, 4, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 1, 'h33, 3, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 1, 'h44, 2, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 1, 'h66, 1, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 0, 'h22, 0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 1, 0,   1, 0, 0, 0, 1, 16, 0, 'h22, 0, 1);
        add(1, 0, 0, 0, 0,  0, 0, 'h00, 0, 0, 0, 1,   1, 0, 0, 0, 1, 16, 0, 'h22, 0, 0);

        foreach (tbl[k]) begin
            rst_n = tbl[k].rst_n[0]; cfg_wr = tbl[k].cw[0]; cfg_par_en = tbl[k].pen[0];
            cfg_par_typ = tbl[k].ptyp[0]; cfg_prescale = 6'(tbl[k].ps); rx_busy = tbl[k].busy[0];
            rx_dv = tbl[k].dv[0]; rx_data = 8'(tbl[k].data); rx_perr = tbl[k].perr[0];
            rx_serr = tbl[k].serr[0]; rd_ready = tbl[k].rdy[0]; clr_err = tbl[k].clr[0];
            step();
            chk_cfg($sformatf("vec%0d", k), tbl[k].e_rxen, tbl[k].e_busy, tbl[k].e_ack,
                    tbl[k].e_pen, tbl[k].e_ptyp, tbl[k].e_ps);
            chk($sformatf("vec%0d rd_valid", k), int'(rd_valid), tbl[k].e_rv);
            chk($sformatf("vec%0d rd_data", k), int'(rd_data), tbl[k].e_rd);
            chk($sformatf("vec%0d level", k), int'(level), tbl[k].e_lvl);
            chk($sformatf("vec%0d overrun", k), int'(overrun), tbl[k].e_ovr);
        end
        idle();

        // Config request while a frame is in flight: old config holds through DRAIN.
        cfg_wr = 1; cfg_par_en = 1; cfg_par_typ = 0; cfg_prescale = 12; rx_busy = 1;
        step();
        chk_cfg("drain0", 0, 1, 0, 0, 1, 16);
        for (int i = 1; i < 20; i++) begin
            idle();
            rx_busy = 1;
            if (i == 5) begin
                cfg_wr = 1; cfg_par_en = 0; cfg_par_typ = 1; cfg_prescale = 40;
            end
            if (i == 19) begin
                rx_dv = 1; rx_data = 8'hA5;
            end
            step();
            chk_cfg($sformatf("drain%0d", i), 0, 1, 0, 0, 1, 16);
        end
        chk("drain push level", int'(level), 1);
        chk("drain push data", int'(rd_data), 'hA5);
        idle();
        step();
        chk_cfg("drain apply", 0, 1, 1, 1, 0, 12);
        step();
        chk_cfg("drain run", 1, 0, 0, 1, 0, 12);
        rd_ready = 1;
        step();
        chk("pop a5 level", int'(level), 0);
        idle();

        // Error counters: single-flag increments, saturation, then clear winning over an event.
        rx_dv = 1; rx_perr = 1;
        step();
        chk("perr only par", int'(par_cnt), 1);
        chk("perr only stp", int'(stp_cnt), 0);
        rx_perr = 0; rx_serr = 1;
        step();
        chk("serr only par", int'(par_cnt), 1);
        chk("serr only stp", int'(stp_cnt), 1);
        rx_perr = 1;
        for (int i = 0; i < 300; i++) step();
        chk("sat par", int'(par_cnt), 255);
        chk("sat stp", int'(stp_cnt), 255);
        chk("sat level", int'(level), 0);
        clr_err = 1;
        step();
        chk("clr par", int'(par_cnt), 0);
        chk("clr stp", int'(stp_cnt), 0);
        idle();

        // Reset while bytes are buffered and a config change is pending.
        for (int i = 0; i < 3; i++) begin
            rx_dv = 1; rx_data = 8'(8'h70 + i);
            step();
        end
        idle();
        cfg_wr = 1; cfg_par_en = 0; cfg_par_typ = 1; cfg_prescale = 33; rx_busy = 1;
        step();
        chk("pre-rst level", int'(level), 3);
        chk("pre-rst busy", int'(cfg_busy), 1);
        idle();
        rst_n = 0;
        step();
        chk_cfg("rst", 0, 0, 0, 1, 0, 8);
        chk("rst rd_valid", int'(rd_valid), 0);
        chk("rst rd_data", int'(rd_data), 0);
        chk("rst level", int'(level), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst par", int'(par_cnt), 0);
        chk("rst stp", int'(stp_cnt), 0);
        idle();
        step();
        chk_cfg("post-rst 1", 1, 0, 0, 1, 0, 8);
        step();
        step();
        chk_cfg("post-rst 3", 1, 0, 0, 1, 0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
